// File: rtl/crc_lfsr_serial.sv
// Serial Galois-LFSR CRC engine: folds one data bit per active cycle, then
// streams the captured CRC LSB-first, pulses ready and re-arms with the seed.
module crc_lfsr_serial #(
  parameter int                   CRC_WIDTH  = 8,
  parameter int                   DATA_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] TAPS       = 8'h03,
  parameter logic [CRC_WIDTH-1:0] SEED       = 8'hD8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data,
  input  logic                 active,
  output logic                 crc_out,
  output logic                 crc_valid,
  output logic [CRC_WIDTH-1:0] crc_word,
  output logic                 crc_ready,
  output logic                 busy,
  output logic                 len_err,
  output logic                 ovr_err
);

  // state | meaning
  // IDLE  | seeded, waiting for the first active bit
  // CALC  | folding data bits into the LFSR
  // OUT   | shifting the captured CRC out LSB-first
  // DONE  | one-cycle completion pulse, reload seed
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT, S_DONE} state_t;

  localparam int DCW = $clog2(DATA_WIDTH) + 1;
  localparam int OCW = $clog2(CRC_WIDTH);
  localparam logic [DCW-1:0] DCNT_MAX  = {DCW{1'b1}};
  localparam logic [DCW-1:0] DCNT_LEN  = DCW'(DATA_WIDTH);
  localparam logic [OCW-1:0] OCNT_LAST = OCW'(CRC_WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CRC_WIDTH-1:0] r_lfsr;
  logic [CRC_WIDTH-1:0] r_crc_word;
  logic [DCW-1:0]       r_dcnt;
  logic [OCW-1:0]       r_ocnt;
  logic                 r_len_err;
  logic                 r_ovr_err;
  logic [CRC_WIDTH-1:0] w_step;

  function automatic logic [CRC_WIDTH-1:0] f_step(input logic [CRC_WIDTH-1:0] l,
                                                  input logic d);
    logic [CRC_WIDTH-1:0] res;
    logic                 fb;
    fb = d ^ l[0];
    res[CRC_WIDTH-1] = fb;
    for (int i = 0; i < CRC_WIDTH - 1; i++) begin
      res[i] = l[i+1] ^ (TAPS[i] & fb);
    end
    return res;
  endfunction

  assign w_step = f_step(r_lfsr, data);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (active) w_next = S_CALC;
      S_CALC:  if (!active) w_next = S_OUT;
      S_OUT:   if (r_ocnt == OCNT_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr     <= SEED;
      r_crc_word <= '0;
      r_dcnt     <= '0;
      r_ocnt     <= '0;
      r_len_err  <= 1'b0;
      r_ovr_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (active) begin
            r_lfsr    <= w_step;
            r_dcnt    <= DCW'(1);
            r_len_err <= 1'b0;
            r_ovr_err <= 1'b0;
          end
        end
        S_CALC: begin
          if (active) begin
            r_lfsr <= w_step;
            if (r_dcnt != DCNT_MAX) r_dcnt <= r_dcnt + 1'b1;
          end else begin
            r_crc_word <= r_lfsr;
            r_len_err  <= (r_dcnt != DCNT_LEN);
            r_ocnt     <= '0;
          end
        end
        S_OUT: begin
          // Bits arriving while the CRC is on the wire are dropped, not folded.
          r_lfsr <= {1'b0, r_lfsr[CRC_WIDTH-1:1]};
          r_ocnt <= r_ocnt + 1'b1;
          if (active) r_ovr_err <= 1'b1;
        end
        S_DONE: begin
          r_lfsr <= SEED;
          if (active) r_ovr_err <= 1'b1;
        end
        default: r_lfsr <= SEED;
      endcase
    end
  end

  assign crc_valid = (r_state == S_OUT);
  assign crc_out   = crc_valid & r_lfsr[0];
  assign crc_ready = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign crc_word  = r_crc_word;
  assign len_err   = r_len_err;
  assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_crc_lfsr_serial.sv
// Bench for crc_lfsr_serial: two instances (default seed and seed 0) driven in
// parallel, checked every cycle against a frame-level CRC model.
module tb_crc_lfsr_serial;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic       active;
  logic [1:0] v_out, v_valid, v_ready, v_busy, v_len, v_ovr;
  logic [7:0] v_word [2];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  crc_lfsr_serial u_dut_d (
    .clk(clk), .rst_n(rst_n), .data(data), .active(active),
    .crc_out(v_out[0]), .crc_valid(v_valid[0]), .crc_word(v_word[0]),
    .crc_ready(v_ready[0]), .busy(v_busy[0]), .len_err(v_len[0]), .ovr_err(v_ovr[0])
  );

  crc_lfsr_serial #(.SEED(8'h00)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .data(data), .active(active),
    .crc_out(v_out[1]), .crc_valid(v_valid[1]), .crc_word(v_word[1]),
    .crc_ready(v_ready[1]), .busy(v_busy[1]), .len_err(v_len[1]), .ovr_err(v_ovr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC of a whole frame, computed directly from the bit list.
  function automatic logic [7:0] crc_fn(input logic [7:0] seed, input logic [63:0] bits,
                                        input int n);
    logic [7:0] l;
    logic       fb;
    l = seed;
    for (int j = 0; j < n; j++) begin
      fb = bits[j] ^ l[0];
      l = l >> 1;
      l[7] = fb;
      if (fb) l = l ^ 8'h03;
    end
    return l;
  endfunction

  // Frame-level model: collect bits, then an 8-bit transmit window, then ready.
  logic [7:0]  m_seed [2] = '{8'hD8, 8'h00};
  logic [63:0] m_bits [2];
  int          m_n    [2];
  bit          m_col  [2];
  int          m_tx   [2];
  bit          m_rdy  [2];
  logic [7:0]  m_word [2];
  bit          m_len  [2];
  bit          m_ovr  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_col[k] = 0; m_tx[k] = -1; m_rdy[k] = 0; m_word[k] = 8'h00;
        m_len[k] = 0; m_ovr[k] = 0; m_n[k] = 0; m_bits[k] = '0;
      end else if (m_rdy[k]) begin
        m_rdy[k] = 0;
        if (active) m_ovr[k] = 1;
      end else if (m_tx[k] >= 0) begin
        if (active) m_ovr[k] = 1;
        if (m_tx[k] == 7) begin
          m_tx[k] = -1;
          m_rdy[k] = 1;
        end else m_tx[k]++;
      end else if (m_col[k]) begin
        if (active) begin
          if (m_n[k] < 64) m_bits[k][m_n[k]] = data;
          m_n[k]++;
        end else begin
          m_word[k] = crc_fn(m_seed[k], m_bits[k], m_n[k]);
          m_len[k]  = (m_n[k] != 8);
          m_col[k]  = 0;
          m_tx[k]   = 0;
        end
      end else if (active) begin
        m_bits[k] = '0;
        m_bits[k][0] = data;
        m_n[k] = 1;
        m_col[k] = 1;
        m_len[k] = 0;
        m_ovr[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid%0d", k), v_valid[k], m_tx[k] >= 0);
        chk($sformatf("ready%0d", k), v_ready[k], m_rdy[k]);
        chk($sformatf("busy%0d", k), v_busy[k], m_col[k] || m_tx[k] >= 0 || m_rdy[k]);
        chk($sformatf("len%0d", k), v_len[k], m_len[k]);
        chk($sformatf("ovr%0d", k), v_ovr[k], m_ovr[k]);
        chk($sformatf("word%0d", k), v_word[k], m_word[k]);
        if (m_tx[k] >= 0) chk($sformatf("crc_out%0d", k), v_out[k], m_word[k][m_tx[k]]);
      end
    end
  end

  task automatic drive(input logic a, input logic d);
    @(negedge clk);
    active = a;
    data   = d;
  endtask

  task automatic send(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, v[i]);
    drive(1'b0, 1'b0);
  endtask

  task automatic drain(input int n, output int nv, output int nr);
    nv = 0;
    nr = 0;
    repeat (n) begin
      drive(1'b0, 1'b0);
      if (v_valid[0]) nv++;
      if (v_ready[0]) nr++;
    end
  endtask

  int nv, nr, lowc;
  logic [7:0] b2b;

  initial begin
    rst_n = 1'b0; active = 1'b0; data = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", v_valid, 2'b00);
    chk("rst_busy", v_busy, 2'b00);
    chk("rst_word_d", v_word[0], 8'h00);
    chk("rst_errs", {v_len, v_ovr, v_ready}, 6'b0);
    rst_n = 1'b1;
    chk_en = 1;

    chk("pin_d8_00", crc_fn(8'hD8, 64'h00, 8), 8'h28);
    chk("pin_z_80", crc_fn(8'h00, 64'h80, 8), 8'h83);
    chk("pin_z_00", crc_fn(8'h00, 64'h00, 8), 8'h00);

    send(64'h00, 8);
    drain(14, nv, nr);
    chk("f00_valid_cycles", nv, 8);
    chk("f00_ready_cycles", nr, 1);
    chk("f00_word_d", v_word[0], 8'h28);
    chk("f00_word_z", v_word[1], 8'h00);

    send(64'h80, 8);
    drain(14, nv, nr);
    chk("f80_word_z", v_word[1], 8'h83);

    send(64'h2D, 6);
    drain(14, nv, nr);
    chk("short_len", v_len[0], 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    chk("len_cleared", v_len[0], 1'b0);
    repeat (6) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drain(14, nv, nr);

    send(64'h3FF, 10);
    drain(14, nv, nr);
    chk("long_len", v_len[0], 1'b1);

    send(64'hFFFFFF, 24);
    drain(14, nv, nr);
    chk("sat_len", v_len[0], 1'b1);

    send(64'h80, 8);
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drain(12, nv, nr);
    chk("ovr_set", v_ovr, 2'b11);
    chk("ovr_word_z", v_word[1], 8'h83);
    send(64'h00, 8);
    drain(14, nv, nr);
    chk("ovr_next_word_z", v_word[1], 8'h00);
    chk("ovr_cleared", v_ovr, 2'b00);

    send(64'h5A, 8);
    lowc = 0;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 1'b0);
      if (!v_busy[0]) lowc++;
    end
    chk("b2b_ready", v_ready[0], 1'b1);
    b2b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b2b[i]);
      if (!v_busy[0]) lowc++;
    end
    drive(1'b0, 1'b0);
    drain(14, nv, nr);
    chk("b2b_busy_low", lowc, 1);
    chk("b2b_word_d", v_word[0], crc_fn(8'hD8, 64'h3C, 8));

    send(64'h15, 6);
    repeat (3) drive(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_valid", v_valid, 2'b00);
    chk("mrst_busy", v_busy, 2'b00);
    chk("mrst_word", {v_word[0], v_word[1]}, 16'h0000);
    chk("mrst_errs", {v_len, v_ovr, v_ready}, 6'b0);
    send(64'h00, 8);
    drain(14, nv, nr);
    chk("mrst_seed_word_d", v_word[0], 8'h28);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/crc_lfsr_serial.md
Name: crc_lfsr_serial

Overview:
- Serial CRC engine that sits directly downstream of the frame bit-serializer in the CRC datapath.
- While the serializer's active strobe is high, it folds one data bit per clock into a Galois LFSR.
- When active drops, it captures the CRC word and shifts it out LSB-first on a serial port with a valid strobe.
- It then pulses completion and re-arms with the seed for the next frame.

Parameters:
- CRC_WIDTH, 8, LFSR/CRC register width in bits (>=2).
- DATA_WIDTH, 8, expected number of data bits per frame; used only for length checking.
- TAPS, 8'h03, feedback mask; bit i (i < CRC_WIDTH-1) XORs feedback into stage i; bit CRC_WIDTH-1 is ignored.
- SEED, 8'hD8, LFSR value loaded at reset and at the start of every frame.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- data  input  1  serial data bit, LSB-first, sampled when active=1.
- active  input  1  high for each cycle that data holds a valid frame bit.
- crc_out  output  1  serial CRC bit, LSB-first; meaningful only when crc_valid=1.
- crc_valid  output  1  high for exactly CRC_WIDTH consecutive cycles per frame.
- crc_word  output  CRC_WIDTH  parallel CRC captured at end of data phase; held until the next capture.
- crc_ready  output  1  one-cycle pulse after the last CRC bit has been driven.
- busy  output  1  high in any state other than IDLE.
- len_err  output  1  sticky; set when a frame's data bit count != DATA_WIDTH; cleared at the next frame start.
- ovr_err  output  1  sticky; set if active=1 during OUT; cleared at the next frame start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, lfsr=SEED, bit counters=0.
  - crc_word=0; crc_out, crc_valid, crc_ready, busy, len_err, ovr_err all 0.
  - Reset takes priority over every other event, including mid-frame; a partial frame is discarded.
- LFSR step, applied on each clock where active=1 in IDLE or CALC:
  - fb = data ^ lfsr[0].
  - lfsr[CRC_WIDTH-1] <= fb.
  - lfsr[i] <= lfsr[i+1] ^ (TAPS[i] & fb) for i = 0..CRC_WIDTH-2.
- IDLE:
  - lfsr holds SEED.
  - On active=1: apply the step (the first bit is consumed in this cycle), set data count=1, clear len_err and ovr_err, go to CALC.
- CALC:
  - active=1: apply the step and increment the data count. The count saturates at 2^(clog2(DATA_WIDTH)+1)-1.
  - active=0: crc_word <= lfsr (the value after the last step); len_err <= (count != DATA_WIDTH); out count=0; go to OUT.
- OUT:
  - crc_valid=1 and crc_out=lfsr[0] (driven from registers, no combinational path from inputs).
  - Each cycle: lfsr shifts right with 0 filled into the MSB; out count increments.
  - After the cycle with out count=CRC_WIDTH-1, go to DONE.
  - If active=1 in any OUT cycle: ovr_err <= 1 and the data bit is dropped; the LFSR is not stepped.
- DONE:
  - crc_ready=1 for this single cycle, crc_valid=0, lfsr <= SEED, go to IDLE.
  - active=1 in DONE is also dropped and sets ovr_err.
- Latency:
  - Let N be the first cycle with active=0 after the data phase.
  - crc_valid rises at N+1 and stays high through N+CRC_WIDTH.
  - crc_ready pulses at N+CRC_WIDTH+1; the earliest next frame bit is accepted at N+CRC_WIDTH+2.
- busy=1 in CALC, OUT and DONE.

Test Plan:
- Reset mid-OUT (after 3 CRC bits) -> next cycle: state IDLE, crc_valid=0, lfsr=SEED, crc_word=0, errors=0.
- SEED=0, 8 bits of data=0 -> crc_word=8'h00; 8 cycles of crc_valid with crc_out=0; crc_ready one cycle later; len_err=0.
- SEED=0, byte 8'h80 LSB-first (seven 0s then 1) -> crc_word=8'h83; crc_out sequence 1,1,0,0,0,0,0,1.
- Default SEED=8'hD8, byte 8'h00 (fb = lfsr[0] each step):
  - Compare crc_word and the serial stream against a bench reference model.
  - Check crc_valid is exactly 8 cycles and crc_ready is exactly 1 cycle.
- Frame of 6 active bits -> len_err=1 after capture; the next frame start clears it.
- Frame of 10 bits -> len_err=1.
- active pulsed high during the 4th OUT cycle -> ovr_err=1; crc_out stream and crc_word unchanged; the bit is not absorbed into the next frame.
- Two back-to-back frames, the second starting the cycle after crc_ready -> second crc_word correct (seed re-applied); busy low for exactly one cycle between frames.
